// File: rtl/sonar_varredura_ctrl_if.sv
// Signal bundle between the sonar sweep sequencer and its environment
// (servo driver, HC-SR04 interface, serial transmitter).
interface sonar_varredura_ctrl_if #(
  parameter int unsigned N_POS = 8
);
  localparam int unsigned W_POS = $clog2(N_POS);

  logic             ligar;
  logic             modo;
  logic             medida_pronto;
  logic             tx_pronto;
  logic [W_POS-1:0] posicao;
  logic             sentido;
  logic             medir;
  logic             transmitir;
  logic             fim_posicao;
  logic             fim_varredura;
  logic             erro_timeout;
  logic             ocupado;
  logic [3:0]       db_estado;

  modport master (
    input  ligar, modo, medida_pronto, tx_pronto,
    output posicao, sentido, medir, transmitir, fim_posicao, fim_varredura,
           erro_timeout, ocupado, db_estado
  );

  modport slave (
    output ligar, modo, medida_pronto, tx_pronto,
    input  posicao, sentido, medir, transmitir, fim_posicao, fim_varredura,
           erro_timeout, ocupado, db_estado
  );
endinterface

// File: rtl/sonar_varredura_ctrl.sv
// Sonar sweep sequencer: steps the servo over N_POS positions, settles, measures,
// transmits each result; ping-pong or single-sweep with a measurement timeout.
module sonar_varredura_ctrl #(
  parameter int unsigned N_POS      = 8,
  parameter int unsigned T_ASSENTAR = 50000000,
  parameter int unsigned T_TIMEOUT  = 1500000
) (
  input logic                    clock,
  input logic                    reset,
  sonar_varredura_ctrl_if.master bus
);
  localparam int unsigned W_POS = $clog2(N_POS);
  localparam int unsigned T_MAX = (T_ASSENTAR > T_TIMEOUT) ? T_ASSENTAR : T_TIMEOUT;
  localparam int unsigned W_CNT = $clog2(T_MAX);

  localparam logic [W_POS-1:0] POS_ULT      = W_POS'(N_POS - 1);
  localparam logic [W_CNT-1:0] CNT_ASSENTAR = W_CNT'(T_ASSENTAR - 1);
  localparam logic [W_CNT-1:0] CNT_TIMEOUT  = W_CNT'(T_TIMEOUT - 1);

  typedef enum logic [3:0] {
    StInicial      = 4'h0,
    StPrepara      = 4'h1,
    StPosiciona    = 4'h2,
    StDispara      = 4'h3,
    StEsperaMedida = 4'h4,
    StTransmite    = 4'h5,
    StEsperaTx     = 4'h6,
    StProxima      = 4'h7,
    StFim          = 4'hF
  } estado_t;

  estado_t          estado_q;
  logic [W_CNT-1:0] cnt_q;
  logic [W_POS-1:0] posicao_q;
  logic             sentido_q;
  logic             medir_q;
  logic             transmitir_q;
  logic             fim_posicao_q;
  logic             fim_varredura_q;
  logic             erro_timeout_q;
  logic             extremo;

  // Current position is the last one in the present direction of travel.
  assign extremo = sentido_q ? (posicao_q == POS_ULT) : (posicao_q == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q        <= StInicial;
      cnt_q           <= '0;
      posicao_q       <= '0;
      sentido_q       <= 1'b1;
      medir_q         <= 1'b0;
      transmitir_q    <= 1'b0;
      fim_posicao_q   <= 1'b0;
      fim_varredura_q <= 1'b0;
      erro_timeout_q  <= 1'b0;
    end else begin
      medir_q         <= 1'b0;
      transmitir_q    <= 1'b0;
      fim_posicao_q   <= 1'b0;
      fim_varredura_q <= 1'b0;
      if (!bus.ligar && (estado_q != StInicial)) begin
        estado_q <= StInicial;
      end else begin
        case (estado_q)
          StInicial: if (bus.ligar) estado_q <= StPrepara;
          StPrepara: begin
            posicao_q <= '0;
            sentido_q <= 1'b1;
            cnt_q     <= '0;
            estado_q  <= StPosiciona;
          end
          StPosiciona: begin
            if (cnt_q == CNT_ASSENTAR) begin
              cnt_q    <= '0;
              medir_q  <= 1'b1;
              estado_q <= StDispara;
            end else begin
              cnt_q <= cnt_q + W_CNT'(1);
            end
          end
          StDispara: begin
            erro_timeout_q <= 1'b0;
            cnt_q          <= '0;
            estado_q       <= StEsperaMedida;
          end
          StEsperaMedida: begin
            if (bus.medida_pronto) begin
              transmitir_q <= 1'b1;
              estado_q     <= StTransmite;
            end else if (cnt_q == CNT_TIMEOUT) begin
              erro_timeout_q  <= 1'b1;
              fim_posicao_q   <= 1'b1;
              fim_varredura_q <= extremo;
              estado_q        <= StProxima;
            end else begin
              cnt_q <= cnt_q + W_CNT'(1);
            end
          end
          StTransmite: estado_q <= StEsperaTx;
          StEsperaTx: begin
            if (bus.tx_pronto) begin
              fim_posicao_q   <= 1'b1;
              fim_varredura_q <= extremo;
              estado_q        <= StProxima;
            end
          end
          StProxima: begin
            cnt_q    <= '0;
            estado_q <= StPosiciona;
            if (sentido_q) begin
              if (posicao_q != POS_ULT) begin
                posicao_q <= posicao_q + W_POS'(1);
              end else if (bus.modo) begin
                estado_q <= StFim;
              end else begin
                sentido_q <= 1'b0;
                posicao_q <= POS_ULT - W_POS'(1);
              end
            end else if (posicao_q == '0) begin
              // Turnaround at the low end applies in both modes.
              sentido_q <= 1'b1;
              posicao_q <= W_POS'(1);
            end else begin
              posicao_q <= posicao_q - W_POS'(1);
            end
          end
          StFim: estado_q <= StFim;
          default: estado_q <= StInicial;
        endcase
      end
    end
  end

  assign bus.posicao       = posicao_q;
  assign bus.sentido       = sentido_q;
  assign bus.medir         = medir_q;
  assign bus.transmitir    = transmitir_q;
  assign bus.fim_posicao   = fim_posicao_q;
  assign bus.fim_varredura = fim_varredura_q;
  assign bus.erro_timeout  = erro_timeout_q;
  assign bus.ocupado       = (estado_q != StInicial) && (estado_q != StFim);
  assign bus.db_estado     = estado_q;

endmodule

// File: tb/tb_sonar_varredura_ctrl.sv
// Directed bench for sonar_varredura_ctrl with small timing parameters and
// measurement/transmit responders answering two cycles after each request.
module tb_sonar_varredura_ctrl;
  localparam int unsigned N_POS      = 4;
  localparam int unsigned T_ASSENTAR = 5;
  localparam int unsigned T_TIMEOUT  = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_medir, n_tx, n_fp, n_fv;
  int pos_log[$];
  bit fv_log[$];
  bit sent_log[$];
  int med_wait  = -1;
  int tx_wait   = -1;
  int med_delay = 2;
  int supp_pos  = -1;

  sonar_varredura_ctrl_if #(.N_POS(N_POS)) bus ();

  sonar_varredura_ctrl #(
    .N_POS      (N_POS),
    .T_ASSENTAR (T_ASSENTAR),
    .T_TIMEOUT  (T_TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Advance one cycle; sample at the falling edge and run the responders.
  task automatic step();
    @(negedge clock);
    bus.medida_pronto = 1'b0;
    bus.tx_pronto     = 1'b0;
    if (med_wait > 0) begin
      med_wait--;
      if (med_wait == 0) begin
        bus.medida_pronto = 1'b1;
        med_wait = -1;
      end
    end
    if (tx_wait > 0) begin
      tx_wait--;
      if (tx_wait == 0) begin
        bus.tx_pronto = 1'b1;
        tx_wait = -1;
      end
    end
    if (bus.medir) begin
      n_medir++;
      if (int'(bus.posicao) != supp_pos) med_wait = med_delay;
    end
    if (bus.transmitir) begin
      n_tx++;
      tx_wait = 2;
    end
    if (bus.fim_posicao) begin
      n_fp++;
      pos_log.push_back(int'(bus.posicao));
      fv_log.push_back(bus.fim_varredura);
      sent_log.push_back(bus.sentido);
    end
    if (bus.fim_varredura) n_fv++;
  endtask

  task automatic clear_logs();
    n_medir = 0; n_tx = 0; n_fp = 0; n_fv = 0;
    pos_log.delete(); fv_log.delete(); sent_log.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.ligar = 1'b0; bus.modo = 1'b0;
    bus.medida_pronto = 1'b0; bus.tx_pronto = 1'b0;
    med_wait = -1; tx_wait = -1; med_delay = 2; supp_pos = -1;
    step(); step();
    reset = 1'b0;
    step();
    clear_logs();
  endtask

  task automatic wait_for(input int code, input int pos, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (int'(bus.db_estado) == code && (pos < 0 || int'(bus.posicao) == pos)) break;
      step();
    end
    n_checks++;
    if (int'(bus.db_estado) != code || (pos >= 0 && int'(bus.posicao) != pos)) begin
      n_fail++;
      $display("FAIL wait_state: got estado %0h pos %0d, required estado %0h pos %0d",
               bus.db_estado, bus.posicao, code, pos);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.posicao !== 2'd0 || bus.sentido !== 1'b1 || bus.db_estado !== 4'h0 ||
        bus.ocupado !== 1'b0 || bus.erro_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: pos %0d sent %b est %0h ocup %b erro %b, required 0 1 0 0 0",
               bus.posicao, bus.sentido, bus.db_estado, bus.ocupado, bus.erro_timeout);
    end
    n_checks++;
    if ({bus.medir, bus.transmitir, bus.fim_posicao, bus.fim_varredura} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_pulses: got %b, required 0000",
               {bus.medir, bus.transmitir, bus.fim_posicao, bus.fim_varredura});
    end
  endtask

  task automatic test_start_timing();
    logic [3:0] exp_est;
    do_reset();
    bus.ligar = 1'b1;
    step();
    n_checks++;
    if (bus.db_estado !== 4'h1 || bus.ocupado !== 1'b1) begin
      n_fail++;
      $display("FAIL start_prepara: est %0h ocup %b, required 1 1", bus.db_estado, bus.ocupado);
    end
    for (int c = 2; c <= 10; c++) begin
      step();
      exp_est = (c <= 6) ? 4'h2 : (c == 7) ? 4'h3 : (c <= 9) ? 4'h4 : 4'h5;
      n_checks++;
      if (bus.db_estado !== exp_est || bus.medir !== (c == 7) || bus.transmitir !== (c == 10)) begin
        n_fail++;
        $display("FAIL start_cycle%0d: est %0h medir %b tx %b, required %0h %b %b", c,
                 bus.db_estado, bus.medir, bus.transmitir, exp_est, c == 7, c == 10);
      end
    end
  endtask

  task automatic test_ping_pong();
    int exp_pos[8]  = '{0, 1, 2, 3, 2, 1, 0, 1};
    bit exp_fv[8]   = '{0, 0, 0, 1, 0, 0, 1, 0};
    bit exp_sent[8] = '{1, 1, 1, 1, 0, 0, 0, 1};
    do_reset();
    bus.modo  = 1'b0;
    bus.ligar = 1'b1;
    for (int i = 0; i < 400 && n_fp < 8; i++) step();
    n_checks++;
    if (n_fp != 8 || n_fv != 2) begin
      n_fail++;
      $display("FAIL pingpong_counts: fim_posicao %0d fim_varredura %0d, required 8 2", n_fp, n_fv);
    end
    for (int i = 0; i < pos_log.size() && i < 8; i++) begin
      n_checks++;
      if (pos_log[i] != exp_pos[i] || fv_log[i] != exp_fv[i] || sent_log[i] != exp_sent[i]) begin
        n_fail++;
        $display("FAIL pingpong_pos%0d: pos %0d fv %b sent %b, required %0d %b %b", i,
                 pos_log[i], fv_log[i], sent_log[i], exp_pos[i], exp_fv[i], exp_sent[i]);
      end
    end
  endtask

  // Continues the running ping-pong sweep: reset lands mid-POSICIONA at posicao 2.
  task automatic test_async_reset();
    step(); step(); step();
    n_checks++;
    if (bus.db_estado !== 4'h2 || bus.posicao !== 2'd2) begin
      n_fail++;
      $display("FAIL areset_pre: est %0h pos %0d, required 2 2", bus.db_estado, bus.posicao);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (bus.posicao !== 2'd0 || bus.sentido !== 1'b1 || bus.db_estado !== 4'h0 ||
        bus.ocupado !== 1'b0 ||
        {bus.medir, bus.transmitir, bus.fim_posicao, bus.fim_varredura} !== 4'b0000) begin
      n_fail++;
      $display("FAIL areset_now: pos %0d sent %b est %0h ocup %b pulses %b, required 0 1 0 0 0000",
               bus.posicao, bus.sentido, bus.db_estado, bus.ocupado,
               {bus.medir, bus.transmitir, bus.fim_posicao, bus.fim_varredura});
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_timeout();
    int nt, cnt;
    do_reset();
    supp_pos  = 1;
    bus.ligar = 1'b1;
    wait_for(3, 1, 200);
    nt  = n_tx;
    cnt = 0;
    step();
    for (int i = 0; i < 60 && bus.db_estado == 4'h4; i++) begin
      cnt++;
      step();
    end
    n_checks++;
    if (cnt != 20) begin
      n_fail++;
      $display("FAIL timeout_len: %0d cycles in ESPERA_MEDIDA, required 20", cnt);
    end
    n_checks++;
    if (bus.db_estado !== 4'h7 || bus.erro_timeout !== 1'b1 || bus.fim_posicao !== 1'b1 ||
        n_tx != nt) begin
      n_fail++;
      $display("FAIL timeout_flag: est %0h erro %b fimpos %b tx %0d, required 7 1 1 %0d",
               bus.db_estado, bus.erro_timeout, bus.fim_posicao, n_tx, nt);
    end
    step();
    n_checks++;
    if (bus.db_estado !== 4'h2 || bus.posicao !== 2'd2) begin
      n_fail++;
      $display("FAIL timeout_next: est %0h pos %0d, required 2 2", bus.db_estado, bus.posicao);
    end
    supp_pos = -1;
    wait_for(3, 2, 50);
    n_checks++;
    if (bus.erro_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_hold: erro %b, required 1", bus.erro_timeout);
    end
    step();
    n_checks++;
    if (bus.erro_timeout !== 1'b0 || bus.db_estado !== 4'h4) begin
      n_fail++;
      $display("FAIL timeout_clear: erro %b est %0h, required 0 4", bus.erro_timeout, bus.db_estado);
    end
  endtask

  task automatic test_priority();
    int cnt;
    do_reset();
    med_delay = 20;
    bus.ligar = 1'b1;
    wait_for(3, 0, 50);
    cnt = 0;
    step();
    for (int i = 0; i < 60 && bus.db_estado == 4'h4; i++) begin
      cnt++;
      step();
    end
    n_checks++;
    if (cnt != 20 || bus.db_estado !== 4'h5 || bus.transmitir !== 1'b1 ||
        bus.erro_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL priority: wait %0d est %0h tx %b erro %b, required 20 5 1 0",
               cnt, bus.db_estado, bus.transmitir, bus.erro_timeout);
    end
    med_delay = 2;
  endtask

  task automatic test_single_abort();
    int nm, nt;
    do_reset();
    bus.modo  = 1'b1;
    bus.ligar = 1'b1;
    wait_for(15, -1, 300);
    n_checks++;
    if (n_medir != 4 || n_tx != 4 || n_fp != 4 || n_fv != 1) begin
      n_fail++;
      $display("FAIL single_counts: medir %0d tx %0d fimpos %0d fimvar %0d, required 4 4 4 1",
               n_medir, n_tx, n_fp, n_fv);
    end
    n_checks++;
    if (fv_log.size() != 4 || fv_log[fv_log.size()-1] != 1'b1) begin
      n_fail++;
      $display("FAIL single_fv_with_last: log size %0d, required fim_varredura on 4th of 4",
               fv_log.size());
    end
    n_checks++;
    if (bus.posicao !== 2'd3 || bus.ocupado !== 1'b0) begin
      n_fail++;
      $display("FAIL single_fim: pos %0d ocup %b, required 3 0", bus.posicao, bus.ocupado);
    end
    repeat (20) step();
    n_checks++;
    if (n_medir != 4 || bus.db_estado !== 4'hF) begin
      n_fail++;
      $display("FAIL single_stop: medir %0d est %0h, required 4 F", n_medir, bus.db_estado);
    end
    bus.ligar = 1'b0;
    step();
    bus.ligar = 1'b1;
    wait_for(6, 1, 100);
    nm = n_medir;
    nt = n_tx;
    bus.ligar = 1'b0;
    step();
    n_checks++;
    if (bus.db_estado !== 4'h0 || bus.posicao !== 2'd1) begin
      n_fail++;
      $display("FAIL abort: est %0h pos %0d, required 0 1", bus.db_estado, bus.posicao);
    end
    repeat (20) step();
    n_checks++;
    if (n_tx != nt || n_medir != nm) begin
      n_fail++;
      $display("FAIL abort_quiet: tx %0d medir %0d, required %0d %0d", n_tx, n_medir, nt, nm);
    end
    bus.ligar = 1'b1;
    step();
    step();
    n_checks++;
    if (bus.db_estado !== 4'h2 || bus.posicao !== 2'd0 || bus.sentido !== 1'b1) begin
      n_fail++;
      $display("FAIL restart: est %0h pos %0d sent %b, required 2 0 1",
               bus.db_estado, bus.posicao, bus.sentido);
    end
  endtask

  initial begin
    bus.ligar = 1'b0;
    bus.modo = 1'b0;
    bus.medida_pronto = 1'b0;
    bus.tx_pronto = 1'b0;
    test_reset();
    test_start_timing();
    test_ping_pong();
    test_async_reset();
    test_timeout();
    test_priority();
    test_single_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
